// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants, digit state type and hex glyph table for the seven-segment driver.
package seg7_pkg;
  localparam int DIGITS = 4;
  localparam logic SEL_VALUE = 1'b0;
  localparam logic SEL_CTRL = 1'b1;
  localparam int CTRL_EN = 0;
  localparam int CTRL_DP_LSB = 4;
  localparam logic [15:0] CTRL_MASK = 16'h00F1;
  localparam logic [15:0] CTRL_RESET = 16'h0001;
  typedef enum logic [1:0] {DIG0, DIG1, DIG2, DIG3} digit_t;
  // Active-high gfedcba glyphs, entry 0 at the LSB end
  localparam logic [16*7-1:0] GLYPHS = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };
endpackage

// File: rtl/seg7_display_driver_hex_decoder.sv
// seg7_hex_decoder: combinational nibble to active-high seven-segment glyph.
module seg7_hex_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] glyph
);
  assign glyph = GLYPHS[7*nibble +: 7];
endmodule

// File: rtl/seg7_display_driver.sv
// seg7_display_driver: CPU-written 4-digit multiplexed seven-segment driver with frame-synchronous commit.
// Optional SEG7_LZ_BLANK_EN enables leading-zero blanking.
module seg7_display_driver
  import seg7_pkg::*;
#(
  parameter int REFRESH_WIDTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        io_we,
  input  logic        io_re,
  input  logic        io_sel,
  input  logic [15:0] io_wdata,
  output logic [15:0] io_rdata,
  output logic        io_ack,
  output logic [3:0]  an,
  output logic [7:0]  seg
);
  logic [REFRESH_WIDTH-1:0] count;
  digit_t digit, digit_next;
  logic [15:0] value_sh, ctrl_sh, value_act, ctrl_act, value_sh_next, ctrl_sh_next;
  logic tick, wrap, blank;
  logic [3:0] nibble;
  logic [6:0] glyph;
  assign tick = &count;
  assign wrap = tick && digit == DIG3;
  assign value_sh_next = (io_we && io_sel == SEL_VALUE) ? io_wdata : value_sh;
  assign ctrl_sh_next = (io_we && io_sel == SEL_CTRL) ? (io_wdata & CTRL_MASK) : ctrl_sh;
  assign nibble = 4'(value_act >> {digit, 2'b00});
`ifdef SEG7_LZ_BLANK_EN
  assign blank = digit != DIG0 && (value_act >> {digit, 2'b00}) == 16'h0;
`else
  assign blank = 1'b0;
`endif
  seg7_hex_decoder u_dec (
    .nibble(nibble),
    .glyph (glyph)
  );
  always_comb digit_next = tick ? digit_t'(digit + 2'd1) : digit;
  always_ff @(posedge clk) digit <= reset ? DIG0 : digit_next;
  always_ff @(posedge clk) begin
    if (reset) begin
      count     <= '0;
      value_sh  <= '0;
      value_act <= '0;
      ctrl_sh   <= CTRL_RESET;
      ctrl_act  <= CTRL_RESET;
      io_ack    <= 1'b0;
      io_rdata  <= '0;
      an        <= 4'hF;
      seg       <= 8'hFF;
    end else begin
      count    <= count + 1'b1;
      value_sh <= value_sh_next;
      ctrl_sh  <= ctrl_sh_next;
      // A write landing on the wrap tick is committed in the same frame
      if (wrap) begin
        value_act <= value_sh_next;
        ctrl_act  <= ctrl_sh_next;
      end
      io_ack <= io_we | io_re;
      if (io_we | io_re) io_rdata <= (io_sel == SEL_CTRL) ? ctrl_sh_next : value_sh_next;
      an  <= ctrl_act[CTRL_EN] ? ~(4'b1 << digit) : 4'hF;
      seg <= ctrl_act[CTRL_EN] ? ~{ctrl_act[CTRL_DP_LSB + int'(digit)], blank ? 7'h0 : glyph} : 8'hFF;
    end
  end
endmodule
